// File: rtl/match_mem_arbiter_pkg.sv
// Shared types and defaults for the match-record memory arbiter.
package match_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FULL  = 2'd2
  } arb_state_t;

  localparam int WORD_W_DEF = 32;

endpackage

// File: rtl/match_mem_arbiter_rr_picker.sv
// Purpose: round-robin pick of the first set request after rr_last, with wrap.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is taken.
module match_mem_arbiter_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_last,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IW-1:0]      win_idx,
  output logic               win_vld
);

  int          cand;
  logic [IW-1:0] cand_idx;

  // Scan from the farthest offset down so the nearest hit after rr_last wins.
  always_comb begin
    win_oh   = '0;
    win_idx  = '0;
    win_vld  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand     = (int'(rr_last) + off) % NUM_REQ;
      cand_idx = IW'(cand);
      if (req[cand_idx]) begin
        win_idx = cand_idx;
        win_vld = 1'b1;
      end
    end
    if (win_vld) win_oh[win_idx] = 1'b1;
  end

endmodule

// File: rtl/match_mem_arbiter.sv
// Purpose: round-robin burst arbiter sharing the match-record RAM write port.
// Latency: grant 1 cycle after req; write strobe combinational from granted valid.
// Backpressure: none to channels; words arriving while full are dropped and flagged.
module match_mem_arbiter
  import match_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = WORD_W_DEF,
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        valid,
  input  logic [NUM_REQ-1:0]        last,
  input  logic [NUM_REQ*WORD_W-1:0] data,
  input  logic                      clear,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      mem_wr_en,
  output logic [AW-1:0]             mem_addr,
  output logic [WORD_W-1:0]         mem_wr_data,
  output logic                      mem_full,
  output logic                      overflow,
  output logic                      timeout_err,
  output logic [AW:0]               record_count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = $clog2(TIMEOUT);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [IW-1:0]       gidx_q, rr_last_q;
  logic [AW-1:0]       wr_ptr_q;
  logic                full_q, ovf_q, tmo_err_q, clr_pend_q, drop_q;
  logic [AW:0]         rec_cnt_q;
  logic [SW-1:0]       stall_q;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IW-1:0]       pick_idx;
  logic                pick_vld;

  logic in_burst, g_vld, g_last, wr, drop, at_top, full_set, tmo, burst_end, apply_clr;

  match_mem_arbiter_rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
    .req     (req),
    .rr_last (rr_last_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  assign in_burst  = (state_q == BURST);
  assign g_vld     = valid[gidx_q];
  assign g_last    = last[gidx_q];
  assign wr        = in_burst & g_vld & ~full_q;
  assign drop      = in_burst & g_vld & full_q;
  assign at_top    = (wr_ptr_q == AW'(DEPTH - 1));
  assign full_set  = wr & at_top;
  assign tmo       = in_burst & ~g_vld & (stall_q == SW'(TIMEOUT - 1));
  assign burst_end = in_burst & ((g_vld & g_last) | tmo);
  // A clear seen during a burst is deferred to the burst-end edge.
  assign apply_clr = (~in_burst & clear) | (burst_end & (clear | clr_pend_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!clear && pick_vld && !full_q) state_d = BURST;
      BURST: begin
        if (burst_end) begin
          if (clear || clr_pend_q)       state_d = IDLE;
          else if (full_q || full_set)   state_d = FULL;
          else                           state_d = IDLE;
        end
      end
      FULL:    if (clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gnt_q      <= '0;
      gidx_q     <= '0;
      rr_last_q  <= IW'(NUM_REQ - 1);
      wr_ptr_q   <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_err_q  <= 1'b0;
      rec_cnt_q  <= '0;
      clr_pend_q <= 1'b0;
      drop_q     <= 1'b0;
      stall_q    <= '0;
    end else begin
      if (state_q == IDLE && !clear && pick_vld && !full_q) begin
        gnt_q     <= pick_oh;
        gidx_q    <= pick_idx;
        rr_last_q <= pick_idx;
        stall_q   <= '0;
        drop_q    <= 1'b0;
      end
      if (in_burst) begin
        stall_q <= g_vld ? '0 : stall_q + SW'(1);
        if (wr) begin
          if (at_top) full_q   <= 1'b1;
          else        wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (drop) begin
          ovf_q  <= 1'b1;
          drop_q <= 1'b1;
        end
        if (clear) clr_pend_q <= 1'b1;
        if (burst_end) begin
          gnt_q      <= '0;
          clr_pend_q <= 1'b0;
          if (tmo)                  tmo_err_q <= 1'b1;
          else if (!drop_q && !drop) rec_cnt_q <= rec_cnt_q + (AW+1)'(1);
        end
      end
      // Placed last so it overrides the burst-end updates above.
      if (apply_clr) begin
        wr_ptr_q  <= '0;
        full_q    <= 1'b0;
        ovf_q     <= 1'b0;
        tmo_err_q <= 1'b0;
        rec_cnt_q <= '0;
      end
    end
  end

  assign gnt          = gnt_q;
  assign mem_wr_en    = wr;
  assign mem_addr     = wr_ptr_q;
  assign mem_wr_data  = data[gidx_q*WORD_W +: WORD_W];
  assign mem_full     = full_q;
  assign overflow     = ovf_q;
  assign timeout_err  = tmo_err_q;
  assign record_count = rec_cnt_q;

endmodule

// File: tb/tb_match_mem_arbiter.sv
// Directed bench for match_mem_arbiter: 4 channels, 8-word memory, timeout 16.
module tb_match_mem_arbiter;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [3:0]   req, valid, last;
  logic [127:0] data;
  logic         clear;
  logic [3:0]   gnt;
  logic         mem_wr_en;
  logic [2:0]   mem_addr;
  logic [31:0]  mem_wr_data;
  logic         mem_full, overflow, timeout_err;
  logic [3:0]   record_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [8];

  typedef struct {
    logic [3:0]   req;
    logic [3:0]   valid;
    logic [3:0]   last;
    logic [127:0] data;
    logic [3:0]   gnt;
    logic         we;
    logic [2:0]   addr;
    logic [31:0]  wd;
  } vec_t;

  vec_t vt [9];

  match_mem_arbiter #(.NUM_REQ(4), .WORD_W(32), .DEPTH(8), .TIMEOUT(16)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .req          (req),
    .valid        (valid),
    .last         (last),
    .data         (data),
    .clear        (clear),
    .gnt          (gnt),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_full     (mem_full),
    .overflow     (overflow),
    .timeout_err  (timeout_err),
    .record_count (record_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wr_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_gnt(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (gnt != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 64'(ok), 64'd1);
  endtask

  function automatic logic [127:0] dd(input logic [31:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic vec_t mkv(input logic [3:0] rq, v, l, input logic [127:0] d,
                               input logic [3:0] g, input logic we, input logic [2:0] a,
                               input logic [31:0] wd);
    vec_t r;
    r.req = rq; r.valid = v; r.last = l; r.data = d;
    r.gnt = g; r.we = we; r.addr = a; r.wd = wd;
    return r;
  endfunction

  initial begin
    n_rst = 1'b0; req = '0; valid = '0; last = '0; data = '0; clear = 1'b0;

    // Reset state
    #2;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_we", 64'(mem_wr_en), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_flags", 64'({mem_full, overflow, timeout_err}), 64'd0);
    chk("rst_rc", 64'(record_count), 64'd0);
    @(negedge clk); n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("idle_nogrant", 64'(gnt), 64'd0);
    end

    // ch0 then ch2, 3-word bursts; off-grant valid/last must be ignored
    vt[0] = mkv(4'b0101, 4'b0000, 4'b0000, dd(32'hA0, 0, 32'hC0, 0), 4'b0000, 1'b0, 3'd0, 32'h0);
    vt[1] = mkv(4'b0100, 4'b0001, 4'b0000, dd(32'hA0, 0, 32'hC0, 0), 4'b0001, 1'b1, 3'd0, 32'hA0);
    vt[2] = mkv(4'b0100, 4'b0101, 4'b0100, dd(32'hA1, 0, 32'hEE, 0), 4'b0001, 1'b1, 3'd1, 32'hA1);
    vt[3] = mkv(4'b0100, 4'b0001, 4'b0001, dd(32'hA2, 0, 32'hC0, 0), 4'b0001, 1'b1, 3'd2, 32'hA2);
    vt[4] = mkv(4'b0100, 4'b0000, 4'b0000, dd(32'h0, 0, 32'hC0, 0),  4'b0000, 1'b0, 3'd3, 32'h0);
    vt[5] = mkv(4'b0000, 4'b0101, 4'b0001, dd(32'hBB, 0, 32'hC0, 0), 4'b0100, 1'b1, 3'd3, 32'hC0);
    vt[6] = mkv(4'b0000, 4'b0100, 4'b0000, dd(32'h0, 0, 32'hC1, 0),  4'b0100, 1'b1, 3'd4, 32'hC1);
    vt[7] = mkv(4'b0000, 4'b0100, 4'b0100, dd(32'h0, 0, 32'hC2, 0),  4'b0100, 1'b1, 3'd5, 32'hC2);
    vt[8] = mkv(4'b0000, 4'b0000, 4'b0000, dd(32'h0, 0, 32'h0, 0),   4'b0000, 1'b0, 3'd6, 32'h0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      req = vt[i].req; valid = vt[i].valid; last = vt[i].last; data = vt[i].data;
      #1;
      chk($sformatf("t2_gnt[%0d]", i), 64'(gnt), 64'(vt[i].gnt));
      chk($sformatf("t2_we[%0d]", i), 64'(mem_wr_en), 64'(vt[i].we));
      chk($sformatf("t2_addr[%0d]", i), 64'(mem_addr), 64'(vt[i].addr));
      if (vt[i].we) chk($sformatf("t2_wd[%0d]", i), 64'(mem_wr_data), 64'(vt[i].wd));
    end
    chk("t2_rc", 64'(record_count), 64'd2);
    chk("t2_mem", 64'({mem[0][7:0], mem[1][7:0], mem[2][7:0], mem[3][7:0], mem[4][7:0], mem[5][7:0]}),
        64'h A0A1A2C0C1C2);

    // Reset restores rr_last; all channels requesting, 1-word bursts
    @(negedge clk); n_rst = 1'b0; #1; n_rst = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_gnt($sformatf("t3_wait[%0d]", k));
      chk($sformatf("t3_order[%0d]", k), 64'(gnt), 64'(4'b0001 << (k % 4)));
      valid = gnt; last = gnt; data = {4{32'h30 + 32'(k)}};
      @(negedge clk);
      valid = '0; last = '0;
      #1;
      chk($sformatf("t3_gap[%0d]", k), 64'(gnt), 64'd0);
    end
    chk("t3_rc", 64'(record_count), 64'd8);
    chk("t3_full", 64'(mem_full), 64'd1);
    chk("t3_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t3_full_nogrant", 64'(gnt), 64'd0);
    end
    @(negedge clk); req = '0; clear = 1'b1;
    @(negedge clk); clear = 1'b0; #1;
    chk("t3_clr", 64'({mem_full, overflow, mem_addr, record_count}), 64'd0);

    // ch1 10-word burst into an 8-word memory
    req = 4'b0010;
    wait_gnt("t4_wait");
    chk("t4_gnt", 64'(gnt), 64'b0010);
    req = '0;
    for (int i = 0; i < 10; i++) begin
      valid = 4'b0010; last = (i == 9) ? 4'b0010 : 4'b0000;
      data = dd(32'h0, 32'h100 + 32'(i), 32'h0, 32'h0);
      #1;
      chk($sformatf("t4_we[%0d]", i), 64'(mem_wr_en), 64'(i < 8));
      if (i < 8) chk($sformatf("t4_addr[%0d]", i), 64'(mem_addr), 64'(i));
      if (i == 7) chk("t4_full_pre", 64'(mem_full), 64'd0);
      @(negedge clk);
    end
    valid = '0; last = '0; #1;
    chk("t4_gnt_end", 64'(gnt), 64'd0);
    chk("t4_full", 64'(mem_full), 64'd1);
    chk("t4_ovf", 64'(overflow), 64'd1);
    chk("t4_rc", 64'(record_count), 64'd0);
    chk("t4_mem", 64'({mem[0], mem[7]}), {32'h100, 32'h107});
    req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t4_full_nogrant", 64'(gnt), 64'd0);
    end
    @(negedge clk); req = '0; clear = 1'b1;
    @(negedge clk); clear = 1'b0; #1;
    chk("t4_clr", 64'({mem_full, overflow, mem_addr}), 64'd0);

    // ch3: two words, then stall until the timeout abort
    req = 4'b1000;
    wait_gnt("t5_wait");
    chk("t5_gnt", 64'(gnt), 64'b1000);
    req = '0;
    valid = 4'b1000; data = dd(0, 0, 0, 32'h51);
    @(negedge clk); data = dd(0, 0, 0, 32'h52);
    @(negedge clk); valid = '0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk($sformatf("t5_hold[%0d]", k), 64'(gnt), 64'b1000);
      @(negedge clk);
    end
    #1;
    chk("t5_gnt_drop", 64'(gnt), 64'd0);
    chk("t5_tmo", 64'(timeout_err), 64'd1);
    chk("t5_addr", 64'(mem_addr), 64'd2);
    chk("t5_rc", 64'(record_count), 64'd0);
    chk("t5_mem", 64'({mem[0], mem[1]}), {32'h51, 32'h52});

    // clear mid-burst is deferred to the burst end
    req = 4'b0001;
    wait_gnt("t6_wait");
    chk("t6_gnt", 64'(gnt), 64'b0001);
    req = '0; valid = 4'b0001; data = dd(32'h61, 0, 0, 0);
    @(negedge clk); valid = '0; clear = 1'b1;
    @(negedge clk); clear = 1'b0; #1;
    chk("t6_pend_tmo", 64'(timeout_err), 64'd1);
    chk("t6_pend_addr", 64'(mem_addr), 64'd3);
    valid = 4'b0001; last = 4'b0001; data = dd(32'h62, 0, 0, 0); #1;
    chk("t6_last_we", 64'({mem_wr_en, mem_addr}), 64'({1'b1, 3'd3}));
    @(negedge clk); valid = '0; last = '0; #1;
    chk("t6_after", 64'({gnt, mem_addr, record_count, timeout_err}), 64'd0);

    // asynchronous reset in the middle of a burst
    req = 4'b0100;
    wait_gnt("t6r_wait");
    chk("t6r_gnt", 64'(gnt), 64'b0100);
    req = '0; valid = 4'b0100; data = dd(0, 0, 32'h71, 0);
    @(negedge clk); #2;
    n_rst = 1'b0; #1;
    chk("t6r_rst", 64'({gnt, mem_wr_en, mem_addr, mem_full, overflow, timeout_err, record_count}), 64'd0);
    @(negedge clk); n_rst = 1'b1; valid = '0; req = 4'b1111;
    wait_gnt("t6r_wait2");
    chk("t6r_rr", 64'(gnt), 64'b0001);
    req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
